// File: rtl/router_pkg.sv
// Constants and types shared across the router: flit width and the
// port index used by the input buffers and the switch.
package router_pkg;

    localparam int FLIT_WIDTH = 18;
    localparam int NUM_PORTS  = 5;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        WEST  = 3'd1,
        NORTH = 3'd2,
        EAST  = 3'd3,
        SOUTH = 3'd4
    } port_idx_e;

endpackage

// File: rtl/input_port_buffer.sv
// Per-port flit FIFO between an incoming link and the switch; req/ack on both
// sides, with ack/req outputs derived from registered occupancy only.
module input_port_buffer
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_req,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       in_ack,
    output logic                       out_req,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ack,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;

    // The switch loops out_ack straight back, so both handshake outputs
    // must stay free of any combinational path from the inputs.
    assign in_ack   = (count != FULL_CNT);
    assign out_req  = (count != '0);
    assign out_data = out_req ? mem[rd_ptr] : '0;

    assign push = in_req & in_ack;
    assign pop  = out_req & out_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Storage is not reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed steps plus random traffic, checked
// against a queue model of the FIFO.
module tb_input_port_buffer;
    import router_pkg::*;

    localparam int DW    = FLIT_WIDTH;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_req;
    logic [DW-1:0] in_data;
    logic          in_ack;
    logic          out_req;
    logic [DW-1:0] out_data;
    logic          out_ack;
    logic [2:0]    count;

    int total  = 0;
    int passed = 0;

    logic [DW-1:0] q[$];

    input_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_req   (in_req),
        .in_data  (in_data),
        .in_ack   (in_ack),
        .out_req  (out_req),
        .out_data (out_data),
        .out_ack  (out_ack),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk({tag, ".in_ack"},   32'(in_ack),   32'(q.size() != DEPTH));
        chk({tag, ".out_req"},  32'(out_req),  32'(q.size() != 0));
        chk({tag, ".out_data"}, 32'(out_data), 32'(head));
        chk({tag, ".count"},    32'(count),    32'(q.size()));
    endtask

    // Called on a falling edge: drive, let one rising edge pass, then check.
    task automatic step(input string tag, input logic r, input logic [DW-1:0] d, input logic a);
        logic do_push, do_pop;
        in_req  = r;
        in_data = d;
        out_ack = a;
        do_push = r && (q.size() < DEPTH);
        do_pop  = a && (q.size() > 0);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(d);
        @(negedge clk);
        check_model(tag);
    endtask

    // Assert reset between edges with the current inputs still applied.
    task automatic mid_reset(input string tag);
        #2 rst = 1'b1;
        #1 q.delete();
        check_model({tag, ".async"});
        in_req  = 1'b0;
        out_ack = 1'b0;
        @(negedge clk);
        check_model({tag, ".held"});
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] expect_out;
        rst     = 1'b0;
        in_req  = 1'b0;
        in_data = '0;
        out_ack = 1'b0;

        // Reset then idle
        @(negedge clk);
        mid_reset("reset");
        for (int i = 0; i < 10; i++) step("idle", 1'b0, '0, 1'b1);

        // Fill with out_ack low
        for (int i = 1; i <= 4; i++) step("fill", 1'b1, DW'(i), 1'b0);
        chk("fill.count_full", 32'(count), 32'd4);
        chk("fill.in_ack_low", 32'(in_ack), 32'd0);
        step("hold5", 1'b1, DW'(5), 1'b0);
        chk("hold5.head", 32'(out_data), 32'h1);
        chk("hold5.count", 32'(count), 32'd4);

        // Full plus pop: pop only, then push and pop together
        step("fullpop1", 1'b1, DW'(5), 1'b1);
        chk("fullpop1.count", 32'(count), 32'd3);
        chk("fullpop1.in_ack", 32'(in_ack), 32'd1);
        step("fullpop2", 1'b1, DW'(5), 1'b1);
        chk("fullpop2.count", 32'(count), 32'd3);

        // Drain in order, then extra acks on empty
        expect_out = DW'(3);
        while (count != 0 && expect_out < 10) begin
            chk("drain.order", 32'(out_data), 32'(expect_out));
            step("drain", 1'b0, '0, 1'b1);
            expect_out++;
        end
        chk("drain.all_out", 32'(expect_out), 32'd6);
        step("empty_ack", 1'b0, '0, 1'b1);
        step("empty_ack", 1'b0, '0, 1'b1);
        chk("empty_ack.count", 32'(count), 32'd0);

        // Streaming from empty with pointer wrap
        for (int i = 0; i < 10; i++) begin
            if (i > 0) chk("stream.order", 32'(out_data), 32'(18'h100 + i - 1));
            step("stream", 1'b1, DW'(18'h100 + i), 1'b1);
        end
        chk("stream.count", 32'(count), 32'd1);
        step("stream_tail", 1'b0, '0, 1'b1);

        // Reset mid-stream at count 3
        for (int i = 0; i < 3; i++) step("prefill", 1'b1, DW'(18'h200 + i), 1'b0);
        chk("prefill.count", 32'(count), 32'd3);
        in_req  = 1'b1;
        in_data = DW'(18'h3FFFF);
        out_ack = 1'b1;
        mid_reset("midrst");
        step("post_rst_push", 1'b1, DW'(18'h2AAAA), 1'b0);
        chk("post_rst.head", 32'(out_data), 32'h2AAAA);
        step("post_rst_pop", 1'b0, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            d = DW'($urandom);
            step("rand", 1'($urandom_range(0, 1)), d, ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 400; i++) begin
            d = DW'($urandom);
            step("rand_skew", ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
